scan_sequencer: RTL and testbench

- Sequences the register file's serial scan chain (test / scan_in / scan_out) to dump, load or swap register contents through byte-wide valid/ready streams.
- Chain order, first bit out to last: bank[CHAIN_REGISTERS-5] … bank[0], r3, r2, r1, r0; each register is shifted LSB-first.
- Sits between the debug/host port and the register file.
- Halts the datapath while a transfer is in progress.

---
 rtl/scan_sequencer.sv | 118 +++++++++++
 tb/tb_scan_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps the register-file scan chain to dump, load or swap contents over byte streams.
// Optional SCAN_SEQ_CRC_EN appends a CRC-8 of every sampled chain bit to DUMP/SWAP output.
module scan_sequencer #(
    parameter int DATA_BUS_WIDTH  = 8,
    parameter int CHAIN_REGISTERS = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_BUS_WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_BUS_WIDTH-1:0] out_data,
    output logic                      test,
    output logic                      scan_in,
    input  logic                      scan_out,
    output logic                      datapath_halt,
    output logic                      done
);
    localparam int BW = DATA_BUS_WIDTH > 1 ? $clog2(DATA_BUS_WIDTH) : 1;
    localparam int CW = $clog2(CHAIN_REGISTERS + 1);
    localparam logic [1:0] OP_DUMP = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_NOP  = 2'd3;

`ifdef SCAN_SEQ_CRC_EN
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, EMIT, NEXT, CRC} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, EMIT, NEXT} state_t;
`endif

    state_t                    state_q, state_d;
    logic [1:0]                op_q;
    logic [CW-1:0]             byte_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [DATA_BUS_WIDTH-1:0] in_buf, out_buf;
    logic                      last_bit, last_byte, done_d;
`ifdef SCAN_SEQ_CRC_EN
    logic [7:0]                crc_q, crc_d;
`endif

    assign last_bit  = bit_cnt == BW'(DATA_BUS_WIDTH - 1);
    assign last_byte = byte_cnt == CW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready     = state_q == IDLE;
        in_ready      = state_q == FETCH && op_q != OP_DUMP;
        out_valid     = state_q == EMIT;
        out_data      = out_buf;
        test          = state_q == SHIFT;
        // DUMP feeds the chain its own output so the contents rotate back into place
        scan_in       = test && (op_q == OP_DUMP ? scan_out : in_buf[bit_cnt]);
        datapath_halt = state_q != IDLE;
`ifdef SCAN_SEQ_CRC_EN
        crc_d = {crc_q[6:0], 1'b0} ^ ({8{crc_q[7] ^ scan_out}} & 8'h07);
        if (state_q == CRC) begin
            out_valid = 1'b1;
            out_data  = DATA_BUS_WIDTH'(crc_q);
        end
`endif
        case (state_q)
            IDLE:    if (cmd_valid && cmd_op != OP_NOP) state_d = FETCH;
            FETCH:   if (op_q == OP_DUMP || in_valid) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = op_q == OP_LOAD ? NEXT : EMIT;
            EMIT:    if (out_ready) state_d = NEXT;
`ifdef SCAN_SEQ_CRC_EN
            NEXT:    state_d = !last_byte ? FETCH : op_q == OP_LOAD ? IDLE : CRC;
            CRC:     if (out_ready) state_d = IDLE;
`else
            NEXT:    state_d = last_byte ? IDLE : FETCH;
`endif
            default: state_d = IDLE;
        endcase
        // reserved op completes straight from IDLE
        done_d = (state_q == IDLE && cmd_valid && cmd_op == OP_NOP) || (state_q != IDLE && state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q     <= OP_DUMP;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            in_buf   <= '0;
            out_buf  <= '0;
            done     <= 1'b0;
        end else begin
            done <= done_d;
            if (state_q == IDLE && cmd_valid) begin
                op_q     <= cmd_op;
                byte_cnt <= CW'(CHAIN_REGISTERS);
            end
            if (in_ready && in_valid) in_buf <= in_data;
            if (test) begin
                out_buf[bit_cnt] <= scan_out;
                bit_cnt          <= last_bit ? '0 : bit_cnt + 1'b1;
            end
            if (state_q == NEXT) byte_cnt <= byte_cnt - 1'b1;
        end
    end

`ifdef SCAN_SEQ_CRC_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                          crc_q <= '0;
        else if (state_q == IDLE && cmd_valid) crc_q <= '0;
        else if (test && op_q != OP_LOAD)    crc_q <= crc_d;
    end
`endif
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: table-driven and randomized checks of scan_sequencer against a register-level model.
module tb_scan_sequencer;
    localparam int DW = 8;
    localparam int NR = 12;
    localparam int NB = DW * NR;
`ifdef SCAN_SEQ_CRC_EN
    localparam int CRC_B = 1;
`else
    localparam int CRC_B = 0;
`endif

    logic          clock = 1'b0, reset = 1'b0;
    logic          cmd_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]    cmd_op = 2'd0;
    logic [DW-1:0] in_data = '0;
    logic          cmd_ready, in_ready, out_valid, test, scan_in, scan_out, datapath_halt, done;
    logic [DW-1:0] out_data;

    scan_sequencer #(.DATA_BUS_WIDTH(DW), .CHAIN_REGISTERS(NR)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .test(test), .scan_in(scan_in), .scan_out(scan_out),
        .datapath_halt(datapath_halt), .done(done)
    );

    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // register file stand-in: chain register i (bank7 first) sits at bits [8i+7:8i], bit 0 leaves first
    logic [NB-1:0] chain, preload_val;
    logic          preload_req = 1'b0;
    always @(posedge clock) begin
        if (preload_req) chain <= preload_val;
        else if (test)   chain <= {scan_in, chain[NB-1:1]};
    end
    assign scan_out = chain[0];

    logic [7:0] regs [NR];
    logic [7:0] stim [NR];
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] pack_regs();
        logic [NB-1:0] v;
        for (int i = 0; i < NR; i++) v[8*i +: 8] = regs[i];
        return v;
    endfunction

    function automatic logic [7:0] crc8();
        logic [7:0] c = 8'h00;
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < DW; b++)
                c = {c[6:0], 1'b0} ^ ((c[7] ^ regs[i][b]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        return op == 2'd3 ? 1 : op == 2'd1 ? NR * (DW + 2) + 1 : NR * (DW + 3) + 1 + CRC_B;
    endfunction

    function automatic int nout_of(input logic [1:0] op);
        return (op == 2'd0 || op == 2'd2) ? NR + CRC_B : 0;
    endfunction

    task automatic preload();
        preload_val = pack_regs();
        preload_req = 1'b1;
        @(posedge clock); #1;
        preload_req = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input bit stall, input int lat, input int nout);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] held;
        int t0, t1, n_in, viol;
        bit seen, hold;
        if (op == 2'd0 || op == 2'd2) begin
            for (int i = 0; i < NR; i++) exp_q.push_back(regs[i]);
            if (CRC_B == 1) exp_q.push_back(crc8());
        end
        if (op == 2'd1 || op == 2'd2) for (int i = 0; i < NR; i++) regs[i] = stim[i];
        cmd_valid = 1'b1;
        cmd_op = op;
        @(negedge clock);
        check("cmd_ready", cmd_ready, 1'b1);
        t0 = cyc;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        n_in = 0; viol = 0; seen = 0; hold = 0; t1 = 0; held = '0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            in_valid  = (op == 2'd1 || op == 2'd2) && n_in < NR && !(stall && $urandom_range(2) == 0);
            in_data   = stim[n_in < NR ? n_in : 0];
            out_ready = !stall || (cyc % 4 == 0);
            cmd_valid = stall;
            cmd_op    = 2'($urandom);
            @(negedge clock);
            if (done) begin
                cmd_valid = 1'b0;
                seen = 1;
                t1 = cyc;
                check("idle_halt", datapath_halt, 1'b0);
            end else begin
                if (!datapath_halt || cmd_ready) viol++;
                if (test && ((out_valid && !out_ready) || (in_ready && !in_valid))) viol++;
                if (op == 2'd1 && out_valid) viol++;
                if (hold && (!out_valid || out_data !== held)) viol++;
                hold = out_valid && !out_ready;
                held = out_data;
                if (in_valid && in_ready) n_in++;
                if (out_valid && out_ready) got_q.push_back(out_data);
                @(posedge clock); #1;
            end
        end
        in_valid = 1'b0;
        check("done_seen", seen, 1'b1);
        if (seen && !stall) check("latency", t1 - t0, lat);
        @(posedge clock); #1;
        @(negedge clock);
        check("done_pulse", done, 1'b0);
        @(posedge clock); #1;
        check("nbytes", got_q.size(), nout);
        check("model_nbytes", exp_q.size(), nout);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check($sformatf("out[%0d]", i), got_q[i], exp_q[i]);
        check("chain", chain, pack_regs());
        check("protocol", viol, 0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] base;
        bit         stall;
        int         lat;
        int         nout;
    } vec_t;
    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nt;
        logic [NB-1:0] v;
        tbl[0] = '{2'd0, 8'h00, 1'b0, NR * (DW + 3) + 1 + CRC_B, NR + CRC_B};
        tbl[1] = '{2'd2, 8'hF0, 1'b0, NR * (DW + 3) + 1 + CRC_B, NR + CRC_B};
        tbl[2] = '{2'd1, 8'h01, 1'b0, NR * (DW + 2) + 1, 0};
        tbl[3] = '{2'd0, 8'h00, 1'b0, NR * (DW + 3) + 1 + CRC_B, NR + CRC_B};
        tbl[4] = '{2'd3, 8'h00, 1'b0, 1, 0};
        tbl[5] = '{2'd0, 8'h00, 1'b1, 0, NR + CRC_B};
        tbl[6] = '{2'd1, 8'h30, 1'b1, 0, 0};
        tbl[7] = '{2'd2, 8'h60, 1'b1, 0, NR + CRC_B};
        tbl[8] = '{2'd0, 8'h00, 1'b1, 0, NR + CRC_B};

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_test", test, 1'b0);
        check("rst_scan_in", scan_in, 1'b0);
        check("rst_halt", datapath_halt, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < NR; i++) regs[i] = i < 8 ? 8'(8'hA7 - i) : 8'(8'h44 - 8'h11 * (i - 8));
        preload();
        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < NR; i++) stim[i] = 8'(tbl[t].base + i);
            run_cmd(tbl[t].op, tbl[t].stall, tbl[t].lat, tbl[t].nout);
        end

        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        nt = 0;
        for (int k = 0; k < 500 && nt < 21; k++) begin
            @(negedge clock);
            if (test) nt++;
            if (nt < 21) begin
                @(posedge clock); #1;
            end
        end
        check("rst_reach", nt, 21);
        reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check("mid_rst_test", test, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_done", done, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        v = pack_regs();
        v = {v[19:0], v[NB-1:20]};
        for (int i = 0; i < NR; i++) regs[i] = v[8*i +: 8];
        run_cmd(2'd0, 1'b0, lat_of(2'd0), nout_of(2'd0));

        for (int i = 0; i < NR; i++) regs[i] = 8'h00;
        preload();
        run_cmd(2'd0, 1'b0, lat_of(2'd0), nout_of(2'd0));
        regs[NR-1] = 8'h01;
        preload();
        run_cmd(2'd0, 1'b0, lat_of(2'd0), nout_of(2'd0));

        for (int r = 0; r < 12; r++) begin
            logic [1:0] op;
            bit st;
            op = 2'($urandom_range(3));
            st = 1'($urandom_range(1));
            for (int i = 0; i < NR; i++) stim[i] = 8'($urandom);
            run_cmd(op, st, lat_of(op), nout_of(op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
